// File: rtl/sensor_scan_ctrl_if.sv
// Bundle of the frame request, sensor handshake and status signals of the sensor scan controller.
// The controller takes the slave side; whoever issues frame requests and drives EOC takes the master side.
interface sensor_scan_ctrl_if;
    logic        start;
    logic [15:0] int_time;
    logic        eoc;
    logic        sensor_clk;
    logic        st;
    logic        pix_valid;
    logic [10:0] pix_index;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] frame_count;

    modport master (
        output start, int_time, eoc,
        input  sensor_clk, st, pix_valid, pix_index, busy, done, timeout_err, frame_count
    );

    modport slave (
        input  start, int_time, eoc,
        output sensor_clk, st, pix_valid, pix_index, busy, done, timeout_err, frame_count
    );
endinterface

// File: rtl/sensor_scan_ctrl.sv
// Linear image sensor scan controller: a free-running divided sensor clock plus a frame sequencer.
// The sequencer drives ST, marks pixel sample points and waits for EOC, with a timeout.
module sensor_scan_ctrl #(
    parameter int DIV         = 8,
    parameter int PIXELS      = 1024,
    parameter int PIX_OFFSET  = 14,
    parameter int MIN_INT     = 6,
    parameter int EOC_TIMEOUT = 2048
) (
    input  logic              clk,
    input  logic              rst,
    sensor_scan_ctrl_if.slave bus
);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PIX_W    = 11;
    // A zero-length integration would never end, so the clamp never goes below one period.
    localparam int MIN_LEN  = (MIN_INT < 1) ? 1 : MIN_INT;
    localparam int SEQ_MAX0 = (MIN_LEN > 65535) ? MIN_LEN : 65535;
    localparam int SEQ_MAX  = (PIX_OFFSET > SEQ_MAX0) ? PIX_OFFSET : SEQ_MAX0;
    localparam int SEQ_W    = $clog2(SEQ_MAX + 1);
    localparam int TMO_W    = (EOC_TIMEOUT > 1) ? $clog2(EOC_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, ARM, INTEG, READ, WAIT_EOC, DONE} state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   divCnt_q;
    logic               sensorClk_q;
    logic               st_q;
    logic               pixValid_q;
    logic [PIX_W-1:0]   pixIndex_q;
    logic               busy_q;
    logic               done_q;
    logic               timeoutErr_q;
    logic [15:0]        frameCount_q;
    logic [SEQ_W-1:0]   intLen_q;
    logic [SEQ_W-1:0]   intLen_d;
    logic [SEQ_W-1:0]   seqCnt_q;
    logic [PIX_W-1:0]   pixCnt_q;
    logic [TMO_W-1:0]   tmoCnt_q;
    logic               eocMeta_q;
    logic               eocSync_q;
    logic               eocPrev_q;
    logic               riseTick;
    logic               eocEdge;

    assign riseTick = (divCnt_q == DIV_W'(DIV - 1)) && !sensorClk_q;
    assign eocEdge  = eocSync_q && !eocPrev_q;
    assign intLen_d = (SEQ_W'(bus.int_time) < SEQ_W'(MIN_LEN)) ? SEQ_W'(MIN_LEN)
                                                                : SEQ_W'(bus.int_time);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divCnt_q    <= '0;
            sensorClk_q <= 1'b0;
        end else if (divCnt_q == DIV_W'(DIV - 1)) begin
            divCnt_q    <= '0;
            sensorClk_q <= ~sensorClk_q;
        end else begin
            divCnt_q    <= divCnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eocMeta_q <= 1'b0;
            eocSync_q <= 1'b0;
            eocPrev_q <= 1'b0;
        end else begin
            eocMeta_q <= bus.eoc;
            eocSync_q <= eocMeta_q;
            eocPrev_q <= eocSync_q;
        end
    end

    // Every phase change happens on a rise tick, except the EOC response, which reacts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            st_q         <= 1'b0;
            pixValid_q   <= 1'b0;
            pixIndex_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
            frameCount_q <= '0;
            intLen_q     <= '0;
            seqCnt_q     <= '0;
            pixCnt_q     <= '0;
            tmoCnt_q     <= '0;
        end else begin
            pixValid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q      <= ARM;
                        busy_q       <= 1'b1;
                        intLen_q     <= intLen_d;
                        timeoutErr_q <= 1'b0;
                    end
                end
                ARM: begin
                    if (riseTick) begin
                        st_q     <= 1'b1;
                        seqCnt_q <= '0;
                        state_q  <= INTEG;
                    end
                end
                INTEG: begin
                    if (riseTick) begin
                        if (seqCnt_q == intLen_q - SEQ_W'(1)) begin
                            st_q     <= 1'b0;
                            seqCnt_q <= '0;
                            pixCnt_q <= '0;
                            state_q  <= READ;
                        end else begin
                            seqCnt_q <= seqCnt_q + SEQ_W'(1);
                        end
                    end
                end
                READ: begin
                    // seqCnt saturates once the offset is covered, so every later tick is a pixel.
                    if (riseTick) begin
                        if (seqCnt_q == SEQ_W'(PIX_OFFSET - 1)) begin
                            pixValid_q <= 1'b1;
                            pixIndex_q <= pixCnt_q;
                            if (pixCnt_q == PIX_W'(PIXELS - 1)) begin
                                tmoCnt_q <= '0;
                                state_q  <= WAIT_EOC;
                            end else begin
                                pixCnt_q <= pixCnt_q + PIX_W'(1);
                            end
                        end else begin
                            seqCnt_q <= seqCnt_q + SEQ_W'(1);
                        end
                    end
                end
                WAIT_EOC: begin
                    if (eocEdge) begin
                        done_q       <= 1'b1;
                        frameCount_q <= frameCount_q + 16'd1;
                        state_q      <= DONE;
                    end else if (riseTick) begin
                        if (tmoCnt_q == TMO_W'(EOC_TIMEOUT - 1)) begin
                            timeoutErr_q <= 1'b1;
                            done_q       <= 1'b1;
                            frameCount_q <= frameCount_q + 16'd1;
                            state_q      <= DONE;
                        end else begin
                            tmoCnt_q <= tmoCnt_q + TMO_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sensor_clk  = sensorClk_q;
    assign bus.st          = st_q;
    assign bus.pix_valid   = pixValid_q;
    assign bus.pix_index   = pixIndex_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeoutErr_q;
    assign bus.frame_count = frameCount_q;
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl with a small configuration (DIV=2, PIXELS=8, PIX_OFFSET=3).
// A negedge monitor timestamps ST edges, pixel pulses and DONE pulses for later comparison.
module tb_sensor_scan_ctrl;
    localparam int DIV         = 2;
    localparam int PIXELS      = 8;
    localparam int PIX_OFFSET  = 3;
    localparam int MIN_INT     = 2;
    localparam int EOC_TIMEOUT = 16;
    localparam int TICK        = 2 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    int   stRiseCyc;
    int   stFallCyc;
    int   lastPixCyc;
    int   doneCount;
    int   doneCyc;
    int   pixCyc[$];
    int   pixIdx[$];
    logic prevSt = 1'b0;

    always #5 clk = ~clk;

    sensor_scan_ctrl_if bus();

    sensor_scan_ctrl #(
        .DIV(DIV), .PIXELS(PIXELS), .PIX_OFFSET(PIX_OFFSET),
        .MIN_INT(MIN_INT), .EOC_TIMEOUT(EOC_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamps use the posedge count, so differences are in FPGA clock cycles.
    always @(negedge clk) begin
        if (bus.st === 1'b1 && prevSt !== 1'b1) stRiseCyc = cyc;
        if (bus.st === 1'b0 && prevSt === 1'b1) stFallCyc = cyc;
        prevSt = bus.st;
        if (bus.pix_valid === 1'b1) begin
            pixCyc.push_back(cyc);
            pixIdx.push_back(int'(bus.pix_index));
            lastPixCyc = cyc;
        end
        if (bus.done === 1'b1) begin
            doneCount++;
            doneCyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] intTime);
        @(negedge clk);
        bus.int_time = intTime;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic clearRecords();
        pixCyc.delete();
        pixIdx.delete();
        stRiseCyc  = -1;
        stFallCyc  = -1;
        lastPixCyc = -1;
        doneCount  = 0;
        doneCyc    = -1;
    endtask

    task automatic waitPixel(input int idx, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (bus.pix_valid === 1'b1 && bus.pix_index === 11'(idx)) seen = 1'b1;
        end
        #1;
        checkOutput({tag, "_pix_seen"}, 32'(seen), 1);
    endtask

    task automatic waitDone(input int limit, output int n);
        n = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) break;
        end
        if (bus.done !== 1'b1) n = limit + 1;
        #1;
    endtask

    task automatic measureSclkPeriod(output int period);
        int   r1;
        logic prev;
        r1     = -1;
        period = -1;
        prev   = bus.sensor_clk;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.sensor_clk === 1'b1 && prev === 1'b0) begin
                if (r1 < 0) r1 = cyc;
                else begin
                    period = cyc - r1;
                    break;
                end
            end
            prev = bus.sensor_clk;
        end
    endtask

    task automatic checkTrain(input string tag, input int stWidth, input int firstOffset);
        checkOutput({tag, "_st_width"}, stFallCyc - stRiseCyc, stWidth);
        checkOutput({tag, "_pix_count"}, pixCyc.size(), PIXELS);
        if (pixCyc.size() > 0)
            checkOutput({tag, "_first_pix"}, pixCyc[0] - stRiseCyc, firstOffset);
        for (int i = 0; i < pixCyc.size(); i++) begin
            checkOutput($sformatf("%s_idx%0d", tag, i), pixIdx[i], i);
            if (i > 0) checkOutput($sformatf("%s_gap%0d", tag, i), pixCyc[i] - pixCyc[i-1], TICK);
        end
    endtask

    task automatic finishWithEoc(input string tag, input int delayCycles);
        int n;
        repeat (delayCycles) @(negedge clk);
        bus.eoc = 1'b1;
        waitDone(10, n);
        bus.eoc = 1'b0;
        checkOutput({tag, "_eoc_latency_ok"}, 32'(n <= 3), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int period;
        int n;
        int fcBefore;
        bus.start    = 1'b0;
        bus.int_time = '0;
        bus.eoc      = 1'b0;
        clearRecords();

        // Asynchronous reset before any clock edge has occurred.
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_sensor_clk", 32'(bus.sensor_clk), 0);
        checkOutput("rst_st", 32'(bus.st), 0);
        checkOutput("rst_pix_valid", 32'(bus.pix_valid), 0);
        checkOutput("rst_pix_index", 32'(bus.pix_index), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        checkOutput("rst_timeout_err", 32'(bus.timeout_err), 0);
        checkOutput("rst_frame_count", 32'(bus.frame_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        measureSclkPeriod(period);
        checkOutput("sclk_period", period, 4);

        $display("[TB] frame 1: INT_TIME=5, EOC after two ticks");
        clearRecords();
        applyStimulus(16'd5);
        checkOutput("f1_busy", 32'(bus.busy), 1);
        waitPixel(PIXELS - 1, "f1");
        checkTrain("f1", 20, 32);
        finishWithEoc("f1", 2 * TICK);
        checkOutput("f1_frame_count", 32'(bus.frame_count), 1);
        checkOutput("f1_timeout_err", 32'(bus.timeout_err), 0);
        @(negedge clk);
        checkOutput("f1_done_width", 32'(bus.done), 0);
        checkOutput("f1_busy_after", 32'(bus.busy), 0);

        $display("[TB] frame 2: INT_TIME=0 clamp, EOC never arrives");
        clearRecords();
        applyStimulus(16'd0);
        waitPixel(PIXELS - 1, "f2");
        checkTrain("f2", 8, 20);
        waitDone(200, n);
        checkOutput("f2_done_count", doneCount, 1);
        checkOutput("f2_timeout_delay", doneCyc - lastPixCyc, EOC_TIMEOUT * TICK);
        checkOutput("f2_timeout_err", 32'(bus.timeout_err), 1);
        checkOutput("f2_frame_count", 32'(bus.frame_count), 2);
        repeat (3) @(negedge clk);
        checkOutput("f2_timeout_sticky", 32'(bus.timeout_err), 1);

        $display("[TB] frame 3: stray START in INTEG and EOC in READ");
        clearRecords();
        fcBefore = int'(bus.frame_count);
        applyStimulus(16'd3);
        checkOutput("f3_timeout_cleared", 32'(bus.timeout_err), 0);
        for (int k = 0; k < 40 && bus.st !== 1'b1; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        bus.int_time = 16'd9;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        waitPixel(1, "f3_early");
        bus.eoc = 1'b1;
        repeat (2) @(negedge clk);
        bus.eoc = 1'b0;
        waitPixel(PIXELS - 1, "f3");
        checkTrain("f3", 12, 24);
        finishWithEoc("f3", TICK);
        checkOutput("f3_frame_count", 32'(bus.frame_count), fcBefore + 1);
        repeat (20) @(negedge clk);
        checkOutput("f3_done_count", doneCount, 1);
        checkOutput("f3_idle_busy", 32'(bus.busy), 0);

        $display("[TB] frame 4: reset at pixel 4, then a clean frame");
        clearRecords();
        applyStimulus(16'd2);
        waitPixel(4, "f4_abort");
        rst = 1'b1;
        #1;
        checkOutput("f4_rst_st", 32'(bus.st), 0);
        checkOutput("f4_rst_pix_index", 32'(bus.pix_index), 0);
        checkOutput("f4_rst_busy", 32'(bus.busy), 0);
        checkOutput("f4_rst_frame_count", 32'(bus.frame_count), 0);
        checkOutput("f4_rst_sensor_clk", 32'(bus.sensor_clk), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("f4_no_done", doneCount, 0);
        checkOutput("f4_idle_busy", 32'(bus.busy), 0);
        checkOutput("f4_count_held", 32'(bus.frame_count), 0);
        clearRecords();
        applyStimulus(16'd4);
        waitPixel(PIXELS - 1, "f5");
        checkTrain("f5", 16, 28);
        finishWithEoc("f5", TICK);
        checkOutput("f5_frame_count", 32'(bus.frame_count), 1);
        checkOutput("f5_timeout_err", 32'(bus.timeout_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sensor_scan_ctrl.md
SENSOR_SCAN_CTRL -- requirements
Module: sensor_scan_ctrl

Interface
REQ-001 Parameter DIV, default 8: FPGA_CLK cycles per SENSOR_CLK half-period; legal range 1 or more.
REQ-002 Parameter PIXELS, default 1024: pixels per frame; legal range 1 to 2048.
REQ-003 Parameter PIX_OFFSET, default 14: sensor clocks after ST falls before pixel 0 is valid; legal range 1 or more.
REQ-004 Parameter MIN_INT, default 6: minimum ST-high length in sensor clocks.
REQ-005 Parameter EOC_TIMEOUT, default 2048: sensor clocks to wait for EOC before declaring an error.
REQ-006 FPGA_CLK  in  1  sole clock; all logic is on its rising edge.
REQ-007 FPGA_RST  in  1  reset, asynchronous, active-high.
REQ-008 START  in  1  level; a frame request, sampled only in IDLE.
REQ-009 INT_TIME  in  16  integration length in sensor clocks, latched when START is accepted.
REQ-010 EOC  in  1  asynchronous end-of-conversion from the sensor.
REQ-011 SENSOR_CLK  out  1  registered sensor drive clock.
REQ-012 ST  out  1  registered sensor start pulse.
REQ-013 PIX_VALID  out  1  one-FPGA_CLK pulse per pixel sample point.
REQ-014 PIX_INDEX  out  11  pixel number, qualified by PIX_VALID.
REQ-015 BUSY  out  1  high whenever the state is not IDLE.
REQ-016 DONE  out  1  one-cycle frame-complete pulse.
REQ-017 TIMEOUT_ERR  out  1  sticky flag: the EOC wait expired.
REQ-018 FRAME_COUNT  out  16  count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-019 SENSOR_CLK SHALL run freely from reset release, independent of state.
- A divider counter counts 0 to DIV-1.
- SENSOR_CLK toggles and the counter returns to 0 when the counter equals DIV-1.
REQ-020 A "rise tick" SHALL be the FPGA_CLK cycle in which SENSOR_CLK is 0 and is about to toggle; ST, PIX_VALID and all state advances are aligned to rise ticks.
REQ-021 States SHALL be IDLE, ARM, INTEG, READ, WAIT_EOC, DONE; the machine resets to IDLE.
REQ-022 IDLE with START=1 SHALL:
- go to ARM;
- latch int_len = max(INT_TIME, MIN_INT);
- clear TIMEOUT_ERR.
REQ-023 START SHALL be ignored in every state other than IDLE.
REQ-024 ARM SHALL wait for the next rise tick T0; at T0, ST becomes 1 and the state becomes INTEG.
REQ-025 INTEG SHALL hold ST=1 until rise tick T0+int_len, where ST becomes 0 and the state becomes READ; ST is therefore high for exactly int_len sensor periods.
REQ-026 In READ, pixel i (i = 0..PIXELS-1) SHALL be signalled at rise tick T0+int_len+PIX_OFFSET+i:
- PIX_VALID=1 for one cycle;
- PIX_INDEX=i.
REQ-027 After pixel PIXELS-1 the state SHALL become WAIT_EOC.
REQ-028 PIX_INDEX SHALL hold its last value when PIX_VALID=0.
REQ-029 EOC SHALL be synchronized through two FFs, followed by a rising-edge detect on the synchronized signal.
REQ-030 EOC edges SHALL be ignored outside WAIT_EOC.
REQ-031 An EOC edge in WAIT_EOC SHALL move the state to DONE; at most 3 FPGA_CLK cycles may elapse from EOC rising to DONE=1.
REQ-032 If EOC_TIMEOUT rise ticks pass in WAIT_EOC without an EOC edge, the block SHALL set TIMEOUT_ERR=1 and go to DONE.
REQ-033 If an EOC edge and the timeout occur in the same cycle, EOC SHALL win and TIMEOUT_ERR SHALL remain 0.
REQ-034 The DONE state SHALL last one cycle:
- DONE=1;
- FRAME_COUNT increments;
- the next state is IDLE.
REQ-035 START held continuously SHALL begin the next frame from IDLE on the cycle after DONE.
REQ-036 All internal counters SHALL be wide enough that they never wrap for any legal parameter values.

Reset
REQ-037 While FPGA_RST=1, the block SHALL immediately force:
- state to IDLE;
- SENSOR_CLK, ST, PIX_VALID, BUSY, DONE and TIMEOUT_ERR to 0;
- PIX_INDEX and FRAME_COUNT to 0;
- the divider, sequencing and timeout counters and the EOC synchronizer to 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no DONE pulse; the first START after release SHALL run a complete frame.

Verification (DIV=2, PIXELS=8, PIX_OFFSET=3, MIN_INT=2, EOC_TIMEOUT=16)
REQ-039 Pulse FPGA_RST high mid-cycle -> all outputs 0 asynchronously; SENSOR_CLK period is 4 cycles after release.
REQ-040 START with INT_TIME=5 -> ST high for 20 cycles; then 8 PIX_VALID pulses 4 cycles apart with indices 0..7, the first at tick T0+8; EOC raised 2 ticks later -> DONE within 3 cycles; FRAME_COUNT=1; TIMEOUT_ERR=0.
REQ-041 START with INT_TIME=0 -> ST high for 8 cycles (MIN_INT clamp); the pixel train starts at tick T0+5.
REQ-042 EOC held low -> at the 16th rise tick in WAIT_EOC, TIMEOUT_ERR=1 and DONE pulses; the next START clears TIMEOUT_ERR.
REQ-043 START pulsed during INTEG and an EOC pulse during READ -> both ignored; the frame completes unchanged and FRAME_COUNT rises by exactly 1.
REQ-044 FPGA_RST asserted while PIX_INDEX=4 -> no DONE pulse and FRAME_COUNT=0; a following frame completes normally.
